imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the CPU datapath reads.
- Receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to sequential word addresses.
- Holds the CPU in reset until the image is loaded, so program loading happens in hardware rather than by bench preload.

Parameters:
- ADDR_WIDTH, 9, byte-address width of instruction memory (512 bytes).
- BASE_ADDR, 0, byte address of the first instruction written; must be word-aligned.
- MAX_WORDS, 128, largest accepted program length in words.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load when not busy.
- in_valid  in  1  byte-stream source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  byte address of the word being written.
- mem_wdata  out  32  instruction word being written.
- cpu_hold  out  1  high keeps the CPU in reset (drive CPU reset from it).
- busy  out  1  load in progress.
- done  out  1  load completed successfully; sticky.
- error  out  1  length rejected; sticky.
- words_loaded  out  16  count of words written in the current or last load.

Behaviour:
- Reset (reset low, asynchronous): state IDLE.
  - Outputs: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, busy=0, done=0, error=0, words_loaded=0.
  - Internal length, byte index and word buffer cleared.
- Byte transfer occurs only on a cycle with in_valid && in_ready. in_data is ignored otherwise. The source may hold in_valid across stall cycles.
- Stream format: 2 length bytes, count[15:8] then count[7:0], followed by count*4 instruction bytes, MSB first per word.
- States:
  - IDLE: in_ready=0. On start go to LEN_HI and set busy=1, cpu_hold=1, done=0, error=0, words_loaded=0, mem_addr=BASE_ADDR.
  - LEN_HI: in_ready=1. On transfer latch count high byte, go to LEN_LO.
  - LEN_LO: in_ready=1. On transfer latch count low byte, then branch on count:
    - count==0: go to DONE.
    - count>MAX_WORDS: go to ERROR.
    - otherwise: go to BYTES with byte index=0.
  - BYTES: in_ready=1. Each transfer shifts in_data into the word buffer (buf = {buf[23:0], in_data}) and increments the byte index mod 4. The transfer that completes byte index 3 moves to WRITE.
  - WRITE: in_ready=0. mem_we=1 for exactly this cycle, with mem_wdata=assembled word and mem_addr=BASE_ADDR+4*words_loaded. On exit words_loaded increments. If the new words_loaded==count go to DONE, else return to BYTES.
  - DONE: busy=0, done=1, cpu_hold=0 (registered; it falls on the cycle after entry). Stays in DONE until start.
  - ERROR: busy=0, error=1, cpu_hold stays 1, no memory write. Stays in ERROR until start.
- Latency: a word's 4th byte is accepted at edge N; mem_we is high during cycle N+1. Minimum cost is 5 cycles per word.
- mem_addr wraps modulo 2^ADDR_WIDTH. Unreachable when MAX_WORDS*4 fits the address range; no special handling is required.
- start while busy is ignored. start in DONE or ERROR restarts: cpu_hold rises and done/error clear on the next edge.
- mem_we is never asserted outside WRITE. mem_wdata and mem_addr hold their last values between writes.
- reset asserted mid-load aborts immediately to the reset values. No partial word is written after reset.

Test Plan:
- Nominal load: start, then bytes 00 02 8C 01 00 04 AC 02 00 08 →
  - writes 0x8C010004 at addr 0 and 0xAC020008 at addr 4, each a single-cycle mem_we;
  - words_loaded=2, done=1, cpu_hold falls one cycle after DONE entry.
- Backpressure/gaps: same stream with in_valid toggled 0 on alternate cycles, plus in_valid held high during WRITE →
  - identical memory contents;
  - no byte is consumed during WRITE (in_ready=0).
- Length bounds:
  - count=0x0000 → DONE with no mem_we, cpu_hold=0.
  - count=129 (00 81) → error=1, cpu_hold=1, no mem_we.
  - count=128 with 512 data bytes → last write at addr 508, done=1.
- Restart and ignored start: pulse start mid-load → no effect on the load. After DONE, pulse start and load 1 word 0x20080005 →
  - done clears and cpu_hold=1 on the next edge;
  - write at addr 0; done reasserts.
- Asynchronous reset mid-word: drop reset after 2 of 4 bytes of word 1 →
  - outputs return to reset values without waiting for a clock edge, including cpu_hold=1;
  - no mem_we follows;
  - a fresh load after release writes correctly from addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Accepts a length-prefixed byte stream (valid/ready), packs big-endian
// 32-bit words and writes them to consecutive word addresses starting at
// BASE_ADDR. The CPU is held in reset (cpu_hold) until the image is complete.
//
// Handshake: a byte moves only on a cycle where in_valid && in_ready at the
// rising clock edge. in_ready depends only on the current state, never on
// in_valid, so the source may hold in_valid high across stall cycles.
`timescale 1ns/1ps

module imem_loader #(
    parameter int                    ADDR_WIDTH = 9,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_BYTES  = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t      state;
    state_t      state_next;

    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [31:0] word_buf;

    logic        xfer;
    logic        can_start;
    logic [15:0] len_full;
    logic        last_word;

    assign xfer      = in_valid && in_ready;
    assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
    // Full length as it will be once the low byte on in_data is latched.
    assign len_full  = {len[15:8], in_data};
    assign last_word = (words_loaded + 16'd1) == len;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_full == 16'd0)                  state_next = S_DONE;
                    else if (len_full > 16'(MAX_WORDS))     state_next = S_ERROR;
                    else                                    state_next = S_BYTES;
                end
            end
            S_BYTES: begin
                if (xfer && (byte_idx == 2'd3)) state_next = S_WRITE;
            end
            S_WRITE: begin
                state_next = last_word ? S_DONE : S_BYTES;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Combinational outputs decoded from the current state.
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_BYTES: in_ready = 1'b1;
            S_WRITE:                     mem_we   = 1'b1;
            default: ;
        endcase
    end

    // Datapath and registered status: length, word assembly, write port, flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len          <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            if (can_start && start) begin
                busy         <= 1'b1;
                cpu_hold     <= 1'b1;
                done         <= 1'b0;
                error        <= 1'b0;
                words_loaded <= '0;
                mem_addr     <= BASE_ADDR;
            end else begin
                case (state)
                    S_LEN_HI: begin
                        if (xfer) len[15:8] <= in_data;
                    end
                    S_LEN_LO: begin
                        if (xfer) begin
                            len[7:0] <= in_data;
                            byte_idx <= 2'd0;
                            if (len_full == 16'd0) begin
                                busy <= 1'b0;
                                done <= 1'b1;
                            end else if (len_full > 16'(MAX_WORDS)) begin
                                busy  <= 1'b0;
                                error <= 1'b1;
                            end
                        end
                    end
                    S_BYTES: begin
                        if (xfer) begin
                            word_buf <= {word_buf[23:0], in_data};
                            byte_idx <= byte_idx + 2'd1;
                            // Present the finished word and its address for the WRITE cycle.
                            if (byte_idx == 2'd3) begin
                                mem_wdata <= {word_buf[23:0], in_data};
                                mem_addr  <= BASE_ADDR + ADDR_WIDTH'({words_loaded, 2'b00});
                            end
                        end
                    end
                    S_WRITE: begin
                        words_loaded <= words_loaded + 16'd1;
                        if (last_word) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                    // CPU release lags DONE entry by one cycle.
                    S_DONE: cpu_hold <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule
